// File: rtl/fib_term_buffer.sv
// fib_term_buffer: FIFO buffer for Fibonacci terms between the term generator
// and a slower, back-pressuring sink. First-word fall-through read side.
// Flags refused pushes (overflow_drop) and 2^WIDTH wrap (wrap_seen).
// Optional feature macro: FIB_CHECK_EN -- when defined, accepted terms are
// checked against the recurrence (p1 + p2) mod 2^WIDTH and seq_err is raised
// on a mismatch; when undefined, the adder and p2 register are not built and
// seq_err is tied low.
module fib_term_buffer #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_term,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_term,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow_drop,
  output logic              wrap_seen,
  output logic              seq_err
);

  localparam logic [ADDR_W:0]   LP_FULL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_EMPTY = '0;
  localparam logic [ADDR_W-1:0] LP_INC   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LP_CINC  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TRACK = 2'd2
  } chk_state_t;

  // Storage and pointers
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  // Checker state and history
  chk_state_t        r_state;
  logic [WIDTH-1:0]  r_p1;
  logic              r_overflow_drop;
  logic              r_wrap_seen;
  logic              r_seq_err;

  // Handshake qualifiers
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_refused;
  logic              w_wrap_hit;
  logic              w_seq_hit;

  assign w_full     = (r_count == LP_FULL);
  assign w_empty    = (r_count == LP_EMPTY);
  assign in_ready   = ~w_full;
  assign out_valid  = ~w_empty;
  assign w_push     = in_valid & ~w_full;
  assign w_pop      = out_ready & ~w_empty;
  assign w_refused  = in_valid & w_full;
  assign out_term   = r_mem[r_rd_ptr];
  assign count      = r_count;

  // Wrap detection: any accepted term smaller than the previous accepted one.
  assign w_wrap_hit = w_push && (r_state != S_EMPTY) && (in_term < r_p1);

`ifdef FIB_CHECK_EN
  logic [WIDTH-1:0]  r_p2;
  logic [WIDTH-1:0]  w_sum;

  // Sum is deliberately truncated to WIDTH so a correctly wrapped term passes.
  assign w_sum      = r_p1 + r_p2;
  assign w_seq_hit  = w_push && (r_state == S_TRACK) && (in_term != w_sum);

  // Second-oldest history term shifts in from p1 on every accepted push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_p2 <= r_p1;
    end
  end
`else
  assign w_seq_hit  = 1'b0;
`endif

  // Data storage: written on accepted push only, not reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_term;
    end
  end

  // Most recent accepted term, kept for the wrap and recurrence compares.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_p1 <= in_term;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_INC;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_INC;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CINC;
        2'b01:   r_count <= r_count - LP_CINC;
        default: r_count <= r_count;
      endcase
    end
  end

  // Checker FSM with registered sticky flags; advances only on accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_EMPTY;
      r_overflow_drop <= 1'b0;
      r_wrap_seen     <= 1'b0;
      r_seq_err       <= 1'b0;
    end else begin
      if (w_refused) begin
        r_overflow_drop <= 1'b1;
      end
      if (w_wrap_hit) begin
        r_wrap_seen <= 1'b1;
      end
      if (w_seq_hit) begin
        r_seq_err <= 1'b1;
      end
      if (w_push) begin
        case (r_state)
          S_EMPTY: r_state <= S_ONE;
          S_ONE:   r_state <= S_TRACK;
          S_TRACK: r_state <= S_TRACK;
          default: r_state <= S_EMPTY;
        endcase
      end
    end
  end

  assign overflow_drop = r_overflow_drop;
  assign wrap_seen     = r_wrap_seen;
  assign seq_err       = r_seq_err;

endmodule

// File: tb/tb_fib_term_buffer.sv
// Self-checking bench for fib_term_buffer with a queue-based reference model.
module tb_fib_term_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int ADDR_W = 3;
`ifdef FIB_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [WIDTH-1:0]  in_term = '0;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_term;
  logic              out_ready = 1'b0;
  logic [ADDR_W:0]   count;
  logic              overflow_drop;
  logic              wrap_seen;
  logic              seq_err;

  fib_term_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_term(in_term), .in_ready(in_ready),
    .out_valid(out_valid), .out_term(out_term), .out_ready(out_ready),
    .count(count), .overflow_drop(overflow_drop),
    .wrap_seen(wrap_seen), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of buffered terms plus history of accepted terms.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_last, m_prev;
  int               m_n;
  bit               m_ovf, m_wrap, m_seq, m_accepted;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_n = 0; m_ovf = 0; m_wrap = 0; m_seq = 0; m_last = '0; m_prev = '0;
  endtask

  task automatic model_update(input bit v, input logic [WIDTH-1:0] t, input bit r);
    bit full, push, pop;
    logic [WIDTH-1:0] sum;
    full = (m_q.size() == DEPTH);
    push = v && !full;
    pop  = (m_q.size() > 0) && r;
    m_accepted = push;
    if (v && full) m_ovf = 1;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_n >= 1 && t < m_last) m_wrap = 1;
      sum = m_last + m_prev;
      if (CHK && m_n >= 2 && t != sum) m_seq = 1;
      m_prev = m_last;
      m_last = t;
      if (m_n < 2) m_n++;
      m_q.push_back(t);
    end
  endtask

  // One clock: present inputs, let the edge happen, advance model, settle.
  task automatic cycle(input bit v, input logic [WIDTH-1:0] t, input bit r);
    in_valid = v; in_term = t; out_ready = r;
    @(posedge clk);
    if (rst) model_update(v, t, r);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_flags", {overflow_drop, wrap_seen, seq_err}, 0);
    rst = 1'b1;
  endtask

  // Compare process: every falling edge, DUT against model.
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_count", count, m_q.size());
      chk("cmp_out_valid", out_valid, m_q.size() > 0);
      chk("cmp_in_ready", in_ready, m_q.size() < DEPTH);
      if (m_q.size() > 0) chk("cmp_out_term", out_term, m_q[0]);
      chk("cmp_ovf", overflow_drop, m_ovf);
      chk("cmp_wrap", wrap_seen, m_wrap);
      chk("cmp_seq", seq_err, m_seq);
    end
  end

  logic [WIDTH-1:0] fibs [8] = '{0, 1, 1, 2, 3, 5, 8, 13};
  logic [WIDTH-1:0] prev_t, fa, fb, nt;

  initial begin
    model_reset();
    do_reset();

    // Fill to full, refuse a ninth term, drain in order.
    for (int i = 0; i < 8; i++) cycle(1, fibs[i], 0);
    chk("fill_count", count, 8);
    chk("fill_in_ready", in_ready, 0);
    cycle(1, 21, 0);
    chk("ovf_set", overflow_drop, 1);
    chk("ovf_count", count, 8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_term", out_term, fibs[i]);
      cycle(0, 0, 1);
    end
    chk("drain_empty", out_valid, 0);
    chk("fill_seq", seq_err, 0);

    // Continuous push+pop: occupancy holds at 1, output trails input by one.
    do_reset();
    prev_t = $urandom;
    cycle(1, prev_t, 1);
    for (int i = 0; i < 10; i++) begin
      chk("stream_count", count, 1);
      chk("stream_term", out_term, prev_t);
      prev_t = $urandom;
      cycle(1, prev_t, 1);
    end

    // Recurrence violation 0,1,1,2,4.
    do_reset();
    cycle(1, 0, 0); cycle(1, 1, 0); cycle(1, 1, 0); cycle(1, 2, 0);
    chk("seq_before", seq_err, 0);
    cycle(1, 4, 0);
    chk("seq_after", seq_err, CHK);
    chk("seq_nowrap", wrap_seen, 0);

    // Wrapped but correct term: fib46, fib47, fib48 mod 2^32.
    do_reset();
    cycle(1, 32'd1836311903, 0); cycle(1, 32'd2971215073, 0);
    chk("wrap_before", wrap_seen, 0);
    cycle(1, 32'd512559680, 0);
    chk("wrap_after", wrap_seen, 1);
    chk("wrap_noseq", seq_err, 0);

    // Mid-drain asynchronous reset.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, fibs[i], 0);
    cycle(0, 0, 1);
    chk("pre_rst_count", count, 5);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_count", count, 0);
    chk("async_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(1, 0, 0); cycle(1, 1, 0); cycle(1, 1, 0);
    chk("post_rst_count", count, 3);
    chk("post_rst_flags", {overflow_drop, wrap_seen, seq_err}, 0);

    // Random traffic with a true Fibonacci stream: no wrap false alarms on seq.
    do_reset();
    fa = 0; fb = 1;
    for (int i = 0; i < 600; i++) begin
      nt = fa;
      cycle($urandom_range(0, 3) != 0, nt, $urandom_range(0, 2) != 0);
      if (m_accepted) begin
        fa = fb; fb = nt + fb;
      end
    end
    chk("rand_fib_seq", seq_err, 0);

    // Random traffic with arbitrary terms and varied pressure.
    for (int s = 0; s < 3; s++) begin
      do_reset();
      for (int i = 0; i < 500; i++) begin
        nt = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 20)) : $urandom;
        cycle($urandom_range(0, 4) < (s + 2), nt, $urandom_range(0, 4) < (3 - s));
      end
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
